// File: rtl/dbg_pkg.sv
// Shared definitions for the data-memory debug dump path: FSM encoding,
// byte ordering on the UART link and debug-link field widths.
package dbg_pkg;

    localparam int DBG_ADDR_W = 32;
    localparam int DBG_DATA_W = 32;
    localparam int TX_BYTE_W  = 8;

    // Words leave the dumper most-significant byte first
    localparam logic BYTE_ORDER_MSB_FIRST = 1'b1;
    localparam logic [1:0] BYTE_LAST_IDX  = 2'd3;

    localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
    localparam logic [2:0] ST_SETUP_ENC   = 3'd1;
    localparam logic [2:0] ST_WAIT_ENC    = 3'd2;
    localparam logic [2:0] ST_CAPTURE_ENC = 3'd3;
    localparam logic [2:0] ST_SEND_ENC    = 3'd4;
    localparam logic [2:0] ST_NEXT_ENC    = 3'd5;
    localparam logic [2:0] ST_DONE_ENC    = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_SETUP   = ST_SETUP_ENC,
        ST_WAIT    = ST_WAIT_ENC,
        ST_CAPTURE = ST_CAPTURE_ENC,
        ST_SEND    = ST_SEND_ENC,
        ST_NEXT    = ST_NEXT_ENC,
        ST_DONE    = ST_DONE_ENC
    } dbg_state_e;

    // Select the idx-th transmitted byte of a word, honouring the link byte order
    function automatic logic [TX_BYTE_W-1:0] get_byte(input logic [DBG_DATA_W-1:0] word,
                                                      input logic [1:0] idx);
        logic [1:0]           sel;
        logic [TX_BYTE_W-1:0] b;
        if (BYTE_ORDER_MSB_FIRST) begin
            sel = 2'd3 - idx;
        end else begin
            sel = idx;
        end
        case (sel)
            2'd3:    b = word[31:24];
            2'd2:    b = word[23:16];
            2'd1:    b = word[15:8];
            2'd0:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dbg_word_serializer.sv
// Turns one loaded 32-bit word into four bytes on a valid/ready link.
// tx_valid is only dropped after the final byte's handshake.
module dbg_word_serializer
    import dbg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DBG_DATA_W-1:0] load_word,
    input  logic                  tx_ready,
    output logic [TX_BYTE_W-1:0]  tx_data,
    output logic                  tx_valid,
    output logic                  tx_last
);

    logic [DBG_DATA_W-1:0] word_buf_r;
    logic [1:0]            byte_idx_r;
    logic [TX_BYTE_W-1:0]  tx_data_r;
    logic                  tx_valid_r;
    logic                  handshake_s;

    assign handshake_s = tx_valid_r && tx_ready;
    assign tx_data     = tx_data_r;
    assign tx_valid    = tx_valid_r;
    assign tx_last     = (byte_idx_r == BYTE_LAST_IDX);

    // Word buffer, byte pointer and the registered byte presented to the link
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_buf_r <= 32'h0000_0000;
            byte_idx_r <= 2'd0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
        end else if (load) begin
            word_buf_r <= load_word;
            byte_idx_r <= 2'd0;
            tx_data_r  <= get_byte(load_word, 2'd0);
            tx_valid_r <= 1'b1;
        end else if (handshake_s) begin
            if (byte_idx_r == BYTE_LAST_IDX) begin
                tx_valid_r <= 1'b0;
            end else begin
                byte_idx_r <= byte_idx_r + 2'd1;
                tx_data_r  <= get_byte(word_buf_r, byte_idx_r + 2'd1);
            end
        end
    end

endmodule

// File: rtl/debug_mem_dumper.sv
// Dumps NUM_WORDS data-memory words over the debug read port and streams
// them MSB first to the debug UART. Owns the sweep FSM, counters and the
// address generator; byte sequencing lives in dbg_word_serializer.
module debug_mem_dumper
    import dbg_pkg::*;
#(
    parameter int NUM_WORDS = 32,
    parameter int ADDR_STEP = 1,
    parameter int READ_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  dbg_on,
    output logic [DBG_ADDR_W-1:0] dbg_addr,
    input  logic [DBG_DATA_W-1:0] dbg_data,
    output logic [TX_BYTE_W-1:0]  tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int WC_W  = $clog2(NUM_WORDS + 1);
    localparam int LAT_W = $clog2(READ_LAT + 1);
    localparam logic [WC_W-1:0]       WORD_LAST = WC_W'(NUM_WORDS - 1);
    localparam logic [LAT_W-1:0]      LAT_LAST  = LAT_W'(READ_LAT - 1);
    localparam logic [DBG_ADDR_W-1:0] ADDR_INC  = DBG_ADDR_W'(ADDR_STEP);

    dbg_state_e            state_r, state_s;
    logic [WC_W-1:0]       word_cnt_r;
    logic [LAT_W-1:0]      lat_cnt_r;
    logic [DBG_ADDR_W-1:0] dbg_addr_r;
    logic                  dbg_on_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  load_s;
    logic                  tx_last_s;
    logic                  word_sent_s;

    assign dbg_on   = dbg_on_r;
    assign dbg_addr = dbg_addr_r;
    assign busy     = busy_r;
    assign done     = done_r;

    assign load_s      = (state_r == ST_CAPTURE);
    assign word_sent_s = tx_valid && tx_ready && tx_last_s;

    dbg_word_serializer u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .load_word(dbg_data),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_last  (tx_last_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode for the sweep
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP:   state_s = ST_WAIT;
            ST_WAIT: begin
                if (lat_cnt_r == LAT_LAST) begin
                    state_s = ST_CAPTURE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_CAPTURE: state_s = ST_SEND;
            ST_SEND: begin
                if (word_sent_s) begin
                    state_s = ST_NEXT;
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_NEXT: begin
                if (word_cnt_r == WORD_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE:    state_s = ST_IDLE;
            default:    state_s = ST_IDLE;
        endcase
    end

    // Registered port controls, counters and address generator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_on_r   <= 1'b0;
            dbg_addr_r <= 32'h0000_0000;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            word_cnt_r <= '0;
            lat_cnt_r  <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        busy_r     <= 1'b1;
                        word_cnt_r <= '0;
                        dbg_addr_r <= 32'h0000_0000;
                    end
                end
                ST_SETUP: begin
                    dbg_on_r  <= 1'b1;
                    lat_cnt_r <= '0;
                end
                ST_WAIT: begin
                    if (lat_cnt_r != LAT_LAST) begin
                        lat_cnt_r <= lat_cnt_r + LAT_W'(1);
                    end
                end
                ST_NEXT: begin
                    if (word_cnt_r == WORD_LAST) begin
                        dbg_on_r <= 1'b0;
                        done_r   <= 1'b1;
                    end else begin
                        word_cnt_r <= word_cnt_r + WC_W'(1);
                        dbg_addr_r <= dbg_addr_r + ADDR_INC;
                        lat_cnt_r  <= '0;
                    end
                end
                ST_DONE: begin
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= busy_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_mem_dumper.sv
// Bench for debug_mem_dumper: 2-word dumps through a 3-cycle-latency memory
// model, byte scoreboard, backpressure, ignored starts and mid-dump reset.
module tb_debug_mem_dumper;

    localparam int NW   = 2;
    localparam int STEP = 1;
    localparam int LAT  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        dbg_on;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    debug_mem_dumper #(.NUM_WORDS(NW), .ADDR_STEP(STEP), .READ_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .dbg_on(dbg_on), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Memory model: data appears LAT cycles after the address changes
    logic [31:0] memw [4];
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= memw[dbg_addr[1:0]];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign dbg_data = pipe[LAT-1];

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q [$];
    int bytes_seen = 0;
    int done_cnt = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Link monitor: scoreboard pop on handshake, hold-stability and done counting
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", {31'd0, tx_valid}, 32'd1);
                chk("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
            end
            if (done) done_cnt++;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_byte", 32'(exp_q.size()), 32'd1);
                end else begin
                    logic [7:0] eb;
                    eb = exp_q.pop_front();
                    chk("tx_byte", {24'd0, tx_data}, {24'd0, eb});
                    chk("tx_addr", dbg_addr, 32'((bytes_seen / 4) * STEP));
                    chk("dbg_on_send", {31'd0, dbg_on}, 32'd1);
                end
                bytes_seen++;
            end
            prev_valid = tx_valid;
            prev_ready = tx_ready;
            prev_data  = tx_data;
        end
    end

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        int          stall_at;
        int          stall_len;
        int          restart_at;
        bit          start_in_done;
        int          exp_bytes;
        int          exp_done;
    } vec_t;

    vec_t tbl [4];

    task automatic push_expected();
        for (int w = 0; w < NW; w++) begin
            logic [31:0] wd;
            wd = memw[w];
            for (int b = 0; b < 4; b++) exp_q.push_back(wd[31-8*b -: 8]);
        end
    endtask

    task automatic run_dump(input vec_t v);
        int  stall_left;
        bit  got_done;
        memw[0] = v.w0;
        memw[1] = v.w1;
        push_expected();
        bytes_seen = 0;
        done_cnt   = 0;
        stall_left = v.stall_len;
        got_done   = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
            start = (cyc == v.restart_at) ? 1'b1 : 1'b0;
            if (bytes_seen == v.stall_at && stall_left > 0) begin
                tx_ready = 1'b0;
                stall_left--;
            end else begin
                tx_ready = 1'b1;
            end
            if (done) begin
                got_done = 1'b1;
                chk("busy_in_done", {31'd0, busy}, 32'd1);
                chk("dbg_on_in_done", {31'd0, dbg_on}, 32'd0);
                if (v.start_in_done) start = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!got_done) chk("done_timeout", 32'd0, 32'd1);
        start    = 1'b0;
        tx_ready = 1'b1;
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("done_pulses", 32'(done_cnt), 32'(v.exp_done));
        chk("byte_count", 32'(bytes_seen), 32'(v.exp_bytes));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("dbg_on_idle", {31'd0, dbg_on}, 32'd0);
    endtask

    initial begin
        tbl[0] = '{32'hDEADBEEF, 32'h01234567, -1, 0, -1, 1'b0, NW*4, 1};
        tbl[1] = '{32'hDEADBEEF, 32'h01234567,  1, 5, -1, 1'b0, NW*4, 1};
        tbl[2] = '{32'hA5C30F96, 32'h7E81FF00,  6, 3,  8, 1'b1, NW*4, 1};
        tbl[3] = '{32'h00000000, 32'hFFFFFFFF,  3, 2, 20, 1'b1, NW*4, 1};
        memw[0] = 32'h0;
        memw[1] = 32'h0;
        memw[2] = 32'hBAD00002;
        memw[3] = 32'hBAD00003;
        for (int i = 0; i < LAT; i++) pipe[i] = 32'h0;

        // Reset values, then a quiet idle period with ready asserted
        rst = 1'b1;
        start = 1'b0;
        tx_ready = 1'b1;
        #22;
        chk("rst_dbg_on", {31'd0, dbg_on}, 32'd0);
        chk("rst_dbg_addr", dbg_addr, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk("idle_quiet", {29'd0, dbg_on, tx_valid, busy}, 32'd0);
        end

        // Table-driven dumps
        for (int t = 0; t < 4; t++) run_dump(tbl[t]);

        // Reset during SEND of word 1, then a fresh dump from address 0
        memw[0] = 32'h11223344;
        memw[1] = 32'h55667788;
        push_expected();
        bytes_seen = 0;
        done_cnt   = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 200 && bytes_seen < 5; c++) begin
            @(posedge clk); #1;
        end
        chk("reach_word1", 32'(bytes_seen), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_dbg_on", {31'd0, dbg_on}, 32'd0);
        chk("arst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("arst_no_done", 32'(done_cnt), 32'd0);
        chk("arst_addr", dbg_addr, 32'd0);
        run_dump(tbl[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
